pc_fetch_unit: RTL
==================

PC_FETCH_UNIT -- requirements
Module: pc_fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, byte address loaded into pc on reset.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port: imem_addr  output  32  fetch byte address, equal to pc.
REQ-006 SHALL have port: imem_ack  input  1  memory has imem_rdata valid this cycle.
REQ-007 SHALL have port: imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port: instr  output  32  registered current instruction.
REQ-009 SHALL have port: op  output  6  instr[31:26], drives decoder opcode.
REQ-010 SHALL have port: instr_valid  output  1  instr is valid and executing this cycle.
REQ-011 SHALL have ports: branch  input  1  and jump  input  1  from the decoder; branch_cond  input  1  branch taken (rs > 0 for bgtz) from the datapath.
REQ-012 SHALL have port: stall  input  1  hold the current instruction in execute.
REQ-013 SHALL have ports: pc  output  32  and pc_plus4  output  32  current PC and PC+4.
REQ-014 SHALL have port: halted  output  1  fetch stopped (only with the REQ-030 macro).

Function
REQ-015 SHALL implement FSM states IDLE, FETCH, EXEC, HALT.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to FETCH.
REQ-017 FETCH SHALL hold imem_req=1 with imem_addr=pc stable until imem_ack=1.
REQ-018 On imem_ack in FETCH, instr SHALL capture imem_rdata and the state SHALL go to EXEC next cycle.
REQ-019 imem_ack outside FETCH SHALL be ignored, with no change to instr or state.
REQ-020 instr_valid SHALL be 1 only in EXEC; imem_req SHALL be 0 in IDLE, EXEC and HALT.
REQ-021 In EXEC with stall=1, the state, pc and instr SHALL hold, and instr_valid SHALL stay 1.
REQ-022 In EXEC with stall=0, pc SHALL load next_pc and the state SHALL go to FETCH.
REQ-023 next_pc priority SHALL be:
- jump=1: {pc_plus4[31:28], instr[25:0], 2'b00};
- else branch=1 and branch_cond=1: pc_plus4 + (sign-extended instr[15:0] << 2);
- else pc_plus4.
REQ-024 jump SHALL override branch when both are 1 (the decoder asserts both for j).
REQ-025 All PC arithmetic SHALL be 32-bit modulo 2^32: pc=32'hFFFF_FFFC gives pc_plus4=32'h0.
REQ-026 Minimum throughput SHALL be 2 cycles per instruction (ack in the first FETCH cycle, no stall).
REQ-027 pc[1:0] SHALL always be 2'b00, including after a jump or branch.

Reset
REQ-028 While rst=1, the following SHALL hold immediately, independent of clk:
- state=IDLE, pc=RESET_PC, instr=0;
- instr_valid=0, imem_req=0, halted=0.
REQ-029 rst asserted mid-FETCH or mid-EXEC SHALL abort the operation; an imem_ack arriving during or after reset SHALL be discarded.

Configuration
REQ-030 Macro PC_FETCH_HALT_EN: when defined, an EXEC with jump=1 and next_pc==pc (self-jump) SHALL enter HALT instead of FETCH.
REQ-031 With PC_FETCH_HALT_EN defined:
- HALT SHALL set halted=1, keep pc unchanged and issue no further fetches;
- HALT SHALL be left only by rst.
REQ-032 Without PC_FETCH_HALT_EN, a self-jump SHALL refetch normally, and halted SHALL be tied to 0.

Verification
REQ-033 Reset release, memory acks each request in the same cycle with 32'h2008_0005 (addi) -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid high every other cycle.
REQ-034 Ack delayed 3 cycles -> imem_req and imem_addr stay stable for 4 cycles; instr_valid is asserted exactly once.
REQ-035 pc=0x40, instr=32'h1C20_FFFE (bgtz, offset -2), branch=1, branch_cond=1 -> next pc=0x3C; with branch_cond=0 -> 0x44.
REQ-036 pc=0x1000_0010, instr=32'h0800_0100 (j), branch=1, jump=1 -> next pc=0x1000_0400.
REQ-037 stall=1 for 5 EXEC cycles -> pc and instr unchanged and no imem_req; rst pulse mid-FETCH -> pc=RESET_PC and imem_req=0 immediately.
REQ-038 PC_FETCH_HALT_EN defined, pc=0x8, instr=32'h0800_0002 -> halted=1 and no further imem_req; undefined -> a refetch of 0x8 occurs.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
//
// Sequencing front end for a multi-cycle processor: fetches one instruction
// word at the current pc, holds it in execute while the rest of the core
// works on it, then advances pc (sequential, branch or jump) and fetches
// again. At best one instruction completes every two cycles.
//
// Optional feature: define PC_FETCH_HALT_EN to stop fetching on a self-jump
// (a jump whose target is its own address). Without the macro a self-jump
// just refetches and halted is tied low.
//
// Parameters
//   RESET_PC     byte address loaded into pc while rst is high
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   imem_req     fetch request, high only while fetching
//   imem_addr    fetch byte address (always pc)
//   imem_ack     instruction memory returns imem_rdata this cycle
//   imem_rdata   fetched instruction word
//   instr        registered current instruction
//   op           instr[31:26], opcode for the decoder
//   instr_valid  instr is executing this cycle
//   branch       decoder: conditional branch
//   jump         decoder: jump (also set alongside branch for j)
//   branch_cond  datapath: branch condition holds
//   stall        hold the current instruction in execute
//   pc           current pc
//   pc_plus4     pc + 4 (modulo 2^32)
//   halted       fetch stopped on a self-jump (feature build only)

module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic        instr_valid,
    input  logic        branch,
    input  logic        jump,
    input  logic        branch_cond,
    input  logic        stall,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted
);

    // Instructions are word aligned; dropping the low bits of the reset
    // address keeps pc[1:0] at zero for every reachable pc.
    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t      state_reg;
    state_t      state_next;
    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] instr_reg;
    logic [31:0] instr_next;

    logic [31:0] seq_pc;
    logic [31:0] branch_offset;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] target_pc;
    logic        enter_halt;

    // ------------------------------------------------------------------
    // Next-pc candidates. All arithmetic wraps at 32 bits, so a pc of
    // 32'hFFFF_FFFC has a sequential successor of zero.
    // ------------------------------------------------------------------
    assign seq_pc        = pc_reg + 32'd4;
    assign branch_offset = {{14{instr_reg[15]}}, instr_reg[15:0], 2'b00};
    assign branch_target = seq_pc + branch_offset;
    // Jump keeps the 256 MB region of the delay-slot-free successor pc.
    assign jump_target   = {seq_pc[31:28], instr_reg[25:0], 2'b00};

    // The decoder raises branch together with jump for j, so jump must win.
    always_comb begin
        target_pc = seq_pc;
        if (jump) begin
            target_pc = jump_target;
        end else if (branch && branch_cond) begin
            target_pc = branch_target;
        end
    end

`ifdef PC_FETCH_HALT_EN
    logic self_jump;

    // A jump to its own address is the program's way of saying "done".
    assign self_jump  = jump && (target_pc == pc_reg);
    assign enter_halt = self_jump;
    assign halted     = (state_reg == HALT);
`else
    assign enter_halt = 1'b0;
    assign halted     = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // pc and instruction registers share the async reset so a reset in the
    // middle of a fetch or execute throws the operation away at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_reg    <= RESET_PC_ALIGNED;
            instr_reg <= 32'h0000_0000;
        end else begin
            pc_reg    <= pc_next;
            instr_reg <= instr_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        instr_next = instr_reg;

        case (state_reg)
            IDLE: begin
                // One quiet cycle after reset release before the first fetch.
                state_next = FETCH;
            end

            FETCH: begin
                // imem_ack is only meaningful here; elsewhere it is ignored.
                if (imem_ack) begin
                    instr_next = imem_rdata;
                    state_next = EXEC;
                end
            end

            EXEC: begin
                if (!stall) begin
                    pc_next = target_pc;
                    if (enter_halt) begin
                        state_next = HALT;
                    end else begin
                        state_next = FETCH;
                    end
                end
            end

            HALT: begin
                // Only rst leaves HALT; pc and instr stay frozen.
                state_next = HALT;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, so rst forces them to
    // their idle values without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign imem_req    = (state_reg == FETCH);
    assign imem_addr   = pc_reg;
    assign instr_valid = (state_reg == EXEC);
    assign instr       = instr_reg;
    assign op          = instr_reg[31:26];
    assign pc          = pc_reg;
    assign pc_plus4    = seq_pc;

endmodule
